// File: rtl/i2c_config_sequencer.sv
// rtl/i2c_config_sequencer.sv - walks a register table and issues one I2C write per entry
//
// Reads NUM_ENTRIES words {slave, reg, data} from an external table, hands each
// to an I2C write engine, retries NACKed or timed-out entries up to MAX_RETRY
// times and inserts GAP_CYCLES idle cycles between transactions.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     synchronous active-low reset
//   start       begin a sequence (accepted only in IDLE/DONE/FAIL)
//   tbl_addr    table read address (always the current entry index)
//   tbl_data    table word, valid one cycle after tbl_addr
//   i2c_data    transaction word for the I2C engine
//   i2c_go      one-cycle transaction request
//   i2c_done    one-cycle transaction-finished pulse
//   i2c_nack    qualifies i2c_done: slave did not acknowledge
//   busy        sequence in progress
//   done        sticky: all entries written
//   error       sticky: sequence aborted
//   fail_index  index of the entry that aborted the sequence

module i2c_config_sequencer #(
   parameter int NUM_ENTRIES    = 16,
   parameter int ADDR_W         = 8,
   parameter int MAX_RETRY      = 3,
   parameter int GAP_CYCLES     = 64,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic [ADDR_W-1:0] tbl_addr,
   input  logic [23:0]       tbl_data,
   output logic [23:0]       i2c_data,
   output logic              i2c_go,
   input  logic              i2c_done,
   input  logic              i2c_nack,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] fail_index
);

   // A zero-width retry counter is not legal, so MAX_RETRY=0 keeps one bit that never counts.
   localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [ADDR_W-1:0]  LAST_IDX  = ADDR_W'(NUM_ENTRIES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
   localparam logic [15:0]        GAP_LAST  = 16'(GAP_CYCLES - 1);
   localparam logic [15:0]        TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, FETCH, LATCH, ISSUE, WAIT, GAP, DONE, FAIL
   } state_t;

   state_t             state, stateNext;
   logic [ADDR_W-1:0]  index, indexNext;
   logic [ADDR_W-1:0]  failIndex, failIndexNext;
   logic [RETRY_W-1:0] retry, retryNext;
   logic [15:0]        gapCnt, gapCntNext;
   logic [15:0]        tmoCnt, tmoCntNext;
   logic [23:0]        i2cData, i2cDataNext;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         index     <= '0;
         failIndex <= '0;
         retry     <= '0;
         gapCnt    <= '0;
         tmoCnt    <= '0;
         i2cData   <= '0;
      end else begin
         state     <= stateNext;
         index     <= indexNext;
         failIndex <= failIndexNext;
         retry     <= retryNext;
         gapCnt    <= gapCntNext;
         tmoCnt    <= tmoCntNext;
         i2cData   <= i2cDataNext;
      end
   end

   always_comb begin
      stateNext     = state;
      indexNext     = index;
      failIndexNext = failIndex;
      retryNext     = retry;
      gapCntNext    = gapCnt;
      tmoCntNext    = tmoCnt;
      i2cDataNext   = i2cData;

      case (state)
         IDLE, DONE, FAIL: begin
            if (start) begin
               stateNext = FETCH;
               indexNext = '0;
               retryNext = '0;
            end
         end
         FETCH: stateNext = LATCH;
         LATCH: begin
            // Table has one cycle of read latency; the word for index is valid now.
            i2cDataNext = tbl_data;
            stateNext   = ISSUE;
         end
         ISSUE: begin
            tmoCntNext = '0;
            stateNext  = WAIT;
         end
         WAIT: begin
            tmoCntNext = tmoCnt + 16'd1;
            if (i2c_done && !i2c_nack) begin
               retryNext  = '0;
               gapCntNext = '0;
               if (index == LAST_IDX) begin
                  stateNext = DONE;
               end else begin
                  indexNext = index + ADDR_W'(1);
                  stateNext = GAP;
               end
            end else if ((i2c_done && i2c_nack) || (tmoCnt == TMO_LAST)) begin
               // TMO_LAST fires on the TIMEOUT_CYCLES-th cycle spent in WAIT.
               if (retry < RETRY_MAX) begin
                  retryNext  = retry + RETRY_W'(1);
                  gapCntNext = '0;
                  stateNext  = GAP;
               end else begin
                  failIndexNext = index;
                  stateNext     = FAIL;
               end
            end
         end
         GAP: begin
            gapCntNext = gapCnt + 16'd1;
            if (gapCnt == GAP_LAST) begin
               stateNext = FETCH;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Status outputs decode the registered state, so done/error are sticky
   // until the next accepted start and can never be high together.
   assign tbl_addr   = index;
   assign i2c_data   = i2cData;
   assign i2c_go     = (state == ISSUE);
   assign busy       = (state == FETCH) || (state == LATCH) || (state == ISSUE) ||
                       (state == WAIT)  || (state == GAP);
   assign done       = (state == DONE);
   assign error      = (state == FAIL);
   assign fail_index = failIndex;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// tb/tb_i2c_config_sequencer.sv - scoreboard bench for i2c_config_sequencer

module tb_i2c_config_sequencer;

   localparam int AW = 4;
   localparam int G  = 4;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n, start, start0;
   logic [AW-1:0] tbl_addr, tblAddr0, fail_index, failIndex0;
   logic [23:0]   tbl_data, tblData0, i2c_data, i2cData0;
   logic          i2c_go, i2cGo0, i2c_done, i2c_nack;
   logic          busy, done, error, busy0, done0, error0;
   logic          noDone;
   assign noDone = 1'b0;

   i2c_config_sequencer #(.NUM_ENTRIES(3), .ADDR_W(AW), .MAX_RETRY(3),
                          .GAP_CYCLES(G), .TIMEOUT_CYCLES(20)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .tbl_addr(tbl_addr),
      .tbl_data(tbl_data), .i2c_data(i2c_data), .i2c_go(i2c_go),
      .i2c_done(i2c_done), .i2c_nack(i2c_nack), .busy(busy), .done(done),
      .error(error), .fail_index(fail_index));

   i2c_config_sequencer #(.NUM_ENTRIES(3), .ADDR_W(AW), .MAX_RETRY(0),
                          .GAP_CYCLES(G), .TIMEOUT_CYCLES(20)) dut0 (
      .clk(clk), .reset_n(reset_n), .start(start0), .tbl_addr(tblAddr0),
      .tbl_data(tblData0), .i2c_data(i2cData0), .i2c_go(i2cGo0),
      .i2c_done(noDone), .i2c_nack(noDone), .busy(busy0), .done(done0),
      .error(error0), .fail_index(failIndex0));

   function automatic logic [23:0] tblWord(input logic [AW-1:0] a);
      logic [7:0] x;
      x = {4'h0, a};
      return {8'h50 + x, 8'h20 + x, 8'hC3 ^ x};
   endfunction

   // Table ROM with one cycle of read latency.
   always @(posedge clk) begin
      tbl_data <= tblWord(tbl_addr);
      tblData0 <= tblWord(tblAddr0);
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int goCount = 0, go0Count = 0, go0Cyc = 0;
   int startCyc = 0, lastDoneCyc = -1, rspCnt = 0;
   int nackLeft[4];
   logic [AW-1:0] curEntry;
   bit latPending = 0, injectSpur = 0;
   logic [23:0] expQ[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial forever @(posedge clk) cyc++;

   // I2C engine model + scoreboard consumer for dut.
   initial begin
      logic [23:0] w;
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      forever begin
         @(negedge clk);
         i2c_done = 1'b0;
         i2c_nack = 1'b0;
         if (!reset_n) rspCnt = 0;
         if (rspCnt > 0) begin
            rspCnt--;
            if (rspCnt == 0) begin
               i2c_done = 1'b1;
               i2c_nack = (nackLeft[curEntry] > 0);
               if (nackLeft[curEntry] > 0) nackLeft[curEntry]--;
               lastDoneCyc = cyc;
            end
         end else if (injectSpur && lastDoneCyc >= 0 && cyc == lastDoneCyc + 2) begin
            i2c_done = 1'b1;
            i2c_nack = 1'b1;
         end
         if (i2c_go) begin
            goCount++;
            if (expQ.size() == 0) begin
               chk("unexpected_go", i2c_go, 0);
            end else begin
               w = expQ.pop_front();
               chk("go_word", i2c_data, w);
            end
            if (latPending) begin
               chk("start_latency", cyc - startCyc, 3);
               latPending = 0;
            end else if (lastDoneCyc >= 0) begin
               chk("gap_spacing", cyc - lastDoneCyc, G + 3);
            end
            rspCnt = 10;
            curEntry = tbl_addr;
         end
         if (i2cGo0) begin
            go0Count++;
            go0Cyc = cyc;
         end
      end
   end

   task automatic pulseStart(input bit newSeq);
      @(negedge clk);
      start = 1'b1;
      if (newSeq) begin
         startCyc = cyc;
         latPending = 1;
         lastDoneCyc = -1;
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitIdle(input int maxCyc);
      int n = 0;
      @(negedge clk);
      while (busy && n < maxCyc) begin
         @(negedge clk);
         n++;
      end
      chk("wait_idle_bound", busy, 0);
   endtask

   task automatic waitGo(input int target, input int maxCyc);
      int n = 0;
      while (goCount < target && n < maxCyc) begin
         @(negedge clk);
         n++;
      end
      chk("wait_go_bound", goCount >= target, 1);
   endtask

   task automatic chkZero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_error"}, error, 0);
      chk({tag, "_go"}, i2c_go, 0);
      chk({tag, "_data"}, i2c_data, 0);
      chk({tag, "_addr"}, tbl_addr, 0);
      chk({tag, "_fidx"}, fail_index, 0);
   endtask

   initial begin
      int n;
      reset_n = 1'b0;
      start   = 1'b1;
      start0  = 1'b0;
      for (int i = 0; i < 4; i++) nackLeft[i] = 0;
      repeat (3) @(negedge clk);
      chkZero("reset");
      chk("reset_error0", error0, 0);
      reset_n = 1'b1;
      start   = 1'b0;
      repeat (2) @(negedge clk);
      chk("start_in_reset_ignored", busy, 0);
      chk("start_in_reset_no_go", goCount, 0);

      // All entries acknowledged.
      for (int i = 0; i < 3; i++) expQ.push_back(tblWord(AW'(i)));
      goCount = 0;
      pulseStart(1);
      waitIdle(400);
      chk("ack_done", done, 1);
      chk("ack_error", error, 0);
      chk("ack_go_count", goCount, 3);
      chk("ack_queue_empty", expQ.size(), 0);

      // Entry 1 NACKs twice; stray start in WAIT, spurious done in GAP.
      nackLeft[1] = 2;
      expQ.push_back(tblWord(0));
      for (int i = 0; i < 3; i++) expQ.push_back(tblWord(1));
      expQ.push_back(tblWord(2));
      goCount = 0;
      injectSpur = 1;
      pulseStart(1);
      chk("restart_clears_done", done, 0);
      waitGo(1, 100);
      repeat (4) @(negedge clk);
      pulseStart(0);
      waitIdle(600);
      injectSpur = 0;
      chk("retry_done", done, 1);
      chk("retry_error", error, 0);
      chk("retry_go_count", goCount, 5);
      chk("retry_queue_empty", expQ.size(), 0);

      // Entry 2 NACKs past the retry limit.
      nackLeft[2] = 4;
      expQ.push_back(tblWord(0));
      expQ.push_back(tblWord(1));
      for (int i = 0; i < 4; i++) expQ.push_back(tblWord(2));
      goCount = 0;
      pulseStart(1);
      waitIdle(600);
      chk("abort_error", error, 1);
      chk("abort_done", done, 0);
      chk("abort_fail_index", fail_index, 2);
      repeat (40) @(negedge clk);
      chk("abort_go_count", goCount, 6);
      chk("abort_queue_empty", expQ.size(), 0);

      // Reset while waiting on entry 1, then restart.
      expQ.push_back(tblWord(0));
      expQ.push_back(tblWord(1));
      goCount = 0;
      pulseStart(1);
      waitGo(2, 100);
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      start   = 1'b1;
      @(negedge clk);
      chkZero("midreset");
      reset_n = 1'b1;
      start   = 1'b0;
      repeat (20) @(negedge clk);
      chk("midreset_go_count", goCount, 2);
      chk("midreset_idle", busy, 0);
      for (int i = 0; i < 3; i++) expQ.push_back(tblWord(AW'(i)));
      goCount = 0;
      pulseStart(1);
      waitIdle(400);
      chk("restart_done", done, 1);
      chk("restart_go_count", goCount, 3);

      // Timeout with no retries on the second instance.
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      n = 0;
      while (!error0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_error", error0, 1);
      chk("tmo_wait_len", cyc - go0Cyc, 21);
      chk("tmo_fail_index", failIndex0, 0);
      chk("tmo_done", done0, 0);
      chk("tmo_go_count", go0Count, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
